// File: rtl/lut_pkg.sv
// -----------------------------------------------------------------------------
// lut_pkg
// Shared definitions for the two-requester lookup-table arbiter:
//   - default key / value widths
//   - FSM state enumeration (INIT fills the table, RUN serves lookups)
//   - default_entry(): power-on content of each table entry
// -----------------------------------------------------------------------------
package lut_pkg;

    localparam int KEY_W_DEF = 4;
    localparam int VAL_W_DEF = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Keys 0..3 map to the odd values 1,3,5,7; every other key defaults to 0xFF.
    function automatic logic [31:0] default_entry(input logic [31:0] key);
        if (key < 32'd4) begin
            return (key << 1) + 32'd1;
        end
        return 32'h0000_00FF;
    endfunction

endpackage

// File: rtl/lut_rr_arb.sv
// -----------------------------------------------------------------------------
// lut_rr_arb
// Two-way round-robin grant. A lone requester is always granted; on a tie the
// requester that was not granted most recently wins. 'block' suppresses both
// grants without disturbing the fairness history.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   valid0, valid1   request inputs
//   block            force both grants low this cycle
//   grant0, grant1   combinational grants (at most one high)
// -----------------------------------------------------------------------------
module lut_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic block,
    output logic grant0,
    output logic grant1
);

    // High when requester 1 holds the most recent grant, so requester 0 wins
    // the next tie. Resets high to favour requester 0 first.
    logic last1;

    assign grant0 = valid0 && !block && (!valid1 || last1);
    assign grant1 = valid1 && !block && (!valid0 || !last1);

    always_ff @(posedge clk) begin
        if (reset) begin
            last1 <= 1'b1;
        end else if (grant0) begin
            last1 <= 1'b0;
        end else if (grant1) begin
            last1 <= 1'b1;
        end
    end

endmodule

// File: rtl/lut_arbiter.sv
// -----------------------------------------------------------------------------
// lut_arbiter
// Lookup table of 2**KEY_W entries shared by two requesters through a
// round-robin valid/ready handshake. After reset the table is filled with its
// default contents, one entry per cycle (INIT), then lookups are served (RUN).
// Each accepted lookup returns its entry one cycle later as a one-cycle pulse.
//
// Build option: define LUT_CFG_WRITE_EN to enable runtime table writes through
// cfg_we/cfg_key/cfg_value. A write takes priority over lookups for that cycle.
// Without the macro the cfg ports are accepted but ignored.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req{0,1}_valid/_key/_ready   lookup handshake per requester
//   rsp{0,1}_valid/_value        response pulse and held table value
//   cfg_we, cfg_key, cfg_value   table write port
//   init_done                    high once the table has been initialised
// -----------------------------------------------------------------------------
import lut_pkg::*;

module lut_arbiter #(
    parameter int KEY_W = KEY_W_DEF,
    parameter int VAL_W = VAL_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [KEY_W-1:0] req0_key,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [KEY_W-1:0] req1_key,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic [VAL_W-1:0] rsp0_value,
    output logic             rsp1_valid,
    output logic [VAL_W-1:0] rsp1_value,
    input  logic             cfg_we,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic [VAL_W-1:0] cfg_value,
    output logic             init_done
);

    localparam int DEPTH = 2 ** KEY_W;

    state_t           state, state_nx;
    logic [KEY_W-1:0] init_cnt;
    logic [VAL_W-1:0] table_q [DEPTH];
    logic             init_we;
    logic             cfg_wr;
    logic             block;
    logic             gnt0, gnt1;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        if (state == ST_INIT && init_cnt == KEY_W'(DEPTH - 1)) begin
            state_nx = ST_RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        init_done = (state == ST_RUN);
        init_we   = (state == ST_INIT);
    end

`ifdef LUT_CFG_WRITE_EN
    assign cfg_wr = cfg_we && (state == ST_RUN);
`else
    logic cfg_unused;
    assign cfg_unused = ^{cfg_we, cfg_key, cfg_value};
    assign cfg_wr     = 1'b0;
`endif

    // Lookups are held off while initialising and while a write owns the table.
    assign block = (state != ST_RUN) || cfg_wr;

    lut_rr_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .block  (block),
        .grant0 (gnt0),
        .grant1 (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Table storage is not reset; INIT rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (init_we) begin
            table_q[init_cnt] <= VAL_W'(default_entry(32'(init_cnt)));
        end else if (cfg_wr) begin
            table_q[cfg_key] <= cfg_value;
        end
    end

    // Response stage: reads the table as it stood at the acceptance edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_value <= '0;
            rsp1_value <= '0;
        end else begin
            rsp0_valid <= gnt0;
            rsp1_valid <= gnt1;
            if (gnt0) begin
                rsp0_value <= table_q[req0_key];
            end
            if (gnt1) begin
                rsp1_value <= table_q[req1_key];
            end
        end
    end

endmodule

// File: tb/tb_lut_arbiter.sv
module tb_lut_arbiter;

    localparam int KEY_W = 4;
    localparam int VAL_W = 8;
    localparam int DEPTH = 16;

`ifdef LUT_CFG_WRITE_EN
    localparam bit CFG_EN = 1'b1;
`else
    localparam bit CFG_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic [KEY_W-1:0] req0_key, req1_key;
    logic             req0_ready, req1_ready;
    logic             rsp0_valid, rsp1_valid;
    logic [VAL_W-1:0] rsp0_value, rsp1_value;
    logic             cfg_we;
    logic [KEY_W-1:0] cfg_key;
    logic [VAL_W-1:0] cfg_value;
    logic             init_done;

    lut_arbiter #(.KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_key   (req0_key),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_key   (req1_key),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_value (rsp0_value),
        .rsp1_valid (rsp1_valid),
        .rsp1_value (rsp1_value),
        .cfg_we     (cfg_we),
        .cfg_key    (cfg_key),
        .cfg_value  (cfg_value),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: table contents, cycles of initialisation left,
    // index of the requester granted most recently, expected responses.
    logic [VAL_W-1:0] m_tab [DEPTH];
    int               m_init_left;
    int               m_last;
    logic             e_rv0, e_rv1;
    logic [VAL_W-1:0] e_val0, e_val1;
    bit               acc0, acc1;

    function automatic logic [VAL_W-1:0] dflt(input int k);
        if (k < 4) return VAL_W'(2 * k + 1);
        return 8'hFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) m_tab[k] = dflt(k);
        m_init_left = DEPTH;
        m_last      = 1;
        e_rv0  = 1'b0;
        e_rv1  = 1'b0;
        e_val0 = '0;
        e_val1 = '0;
    endtask

    // Called #1 after a rising edge with inputs already applied.
    task automatic cycle();
        bit run, blk, e_r0, e_r1;
        #3;
        run  = (m_init_left == 0);
        blk  = !run || (CFG_EN && cfg_we);
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!blk) begin
            if (req0_valid && req1_valid) begin
                if (m_last == 1) e_r0 = 1'b1;
                else             e_r1 = 1'b1;
            end else begin
                e_r0 = req0_valid;
                e_r1 = req1_valid;
            end
        end
        if (!reset) begin
            chk("ready0", 32'(req0_ready), 32'(e_r0));
            chk("ready1", 32'(req1_ready), 32'(e_r1));
            chk("init_done", 32'(init_done), 32'(run));
        end
        acc0 = e_r0 && !reset;
        acc1 = e_r1 && !reset;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            e_rv0 = acc0;
            e_rv1 = acc1;
            if (acc0) begin e_val0 = m_tab[req0_key]; m_last = 0; end
            if (acc1) begin e_val1 = m_tab[req1_key]; m_last = 1; end
            if (run && CFG_EN && cfg_we) m_tab[cfg_key] = cfg_value;
            if (!run) m_init_left--;
        end
        #1;
        chk("rsp0_valid", 32'(rsp0_valid), 32'(e_rv0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(e_rv1));
        chk("rsp0_value", 32'(rsp0_value), 32'(e_val0));
        chk("rsp1_value", 32'(rsp1_value), 32'(e_val1));
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_key   = '0;
        req1_key   = '0;
        cfg_we     = 1'b0;
        cfg_key    = '0;
        cfg_value  = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset, then initialisation with both requesters pending.
        cycle();
        cycle();
        reset      = 1'b0;
        req0_valid = 1'b1;
        req0_key   = 4'd0;
        req1_valid = 1'b1;
        req1_key   = 4'd9;
        repeat (16) cycle();

        // Contention: grants alternate starting with requester 0.
        repeat (4) cycle();
        chk("rr_last_grant_req1", 32'(rsp1_valid), 32'd1);
        chk("rr_value_key9", 32'(rsp1_value), 32'hFF);

        // Single requester, key 2.
        req1_valid = 1'b0;
        req0_key   = 4'd2;
        cycle();
        req0_valid = 1'b0;
        cycle();
        chk("key2_value", 32'(rsp0_value), 32'h05);

        // Write to key 9 racing a lookup of key 9.
        cfg_we     = 1'b1;
        cfg_key    = 4'd9;
        cfg_value  = 8'h3C;
        req1_valid = 1'b1;
        req1_key   = 4'd9;
        repeat (3) begin
            cycle();
            cfg_we = 1'b0;
            if (acc1) req1_valid = 1'b0;
        end
        chk("key9_after_write", 32'(rsp1_value), CFG_EN ? 32'h3C : 32'hFF);

        // Reset in RUN with a lookup being accepted; defaults restored.
        req1_valid = 1'b1;
        req1_key   = 4'd9;
        reset      = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (20) begin
            cycle();
            if (acc1) req1_valid = 1'b0;
        end
        chk("key9_after_reset", 32'(rsp1_value), 32'hFF);

        // Randomised traffic, writes and occasional resets.
        repeat (600) begin
            if (!req0_valid && $urandom_range(0, 2) != 0) begin
                req0_valid = 1'b1;
                req0_key   = KEY_W'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) != 0) begin
                req1_valid = 1'b1;
                req1_key   = KEY_W'($urandom);
            end
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_key   = KEY_W'($urandom);
            cfg_value = VAL_W'($urandom);
            reset     = ($urandom_range(0, 199) == 0);
            cycle();
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lut_arbiter.md
LUT_ARBITER -- requirements
Module: lut_arbiter

Interface
REQ-001 Parameter KEY_W, default 4, key width; table depth SHALL be 2**KEY_W.
REQ-002 Parameter VAL_W, default 8, entry width.
REQ-003 Clk  input  1  sole clock; all state SHALL update on rising edge only.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester n presents a lookup.
REQ-006 req0_key / req1_key  input  KEY_W  lookup key of requester n.
REQ-007 req0_ready / req1_ready  output  1  lookup of requester n accepted this cycle.
REQ-008 rsp0_valid / rsp1_valid  output  1  one-cycle pulse, response for requester n.
REQ-009 rsp0_value / rsp1_value  output  VAL_W  table entry for the accepted key.
REQ-010 cfg_we  input  1  table write strobe.
REQ-011 cfg_key  input  KEY_W  write address; cfg_value  input  VAL_W  write data.
REQ-012 init_done  output  1  high once the table initialisation sequence completes.

Function
REQ-013 FSM states: INIT, RUN; Reset SHALL force INIT with init counter = 0.
REQ-014 INIT: one entry per cycle written with its default (key 0->0x01, 1->0x03, 2->0x05, 3->0x07, all others 0xFF), counter incrementing; after entry 2**KEY_W-1, next state RUN.
REQ-015 In INIT: req*_ready=0, rsp*_valid=0, cfg_we ignored, init_done=0; INIT takes exactly 2**KEY_W cycles (16 default).
REQ-016 In RUN: init_done=1; state SHALL remain RUN until Reset.
REQ-017 Handshake: a lookup is accepted on a cycle with reqN_valid=1 and reqN_ready=1; at most one lookup accepted per cycle.
REQ-018 readyN SHALL be combinational from valid inputs, grant state and cfg_we; requesters SHALL hold key stable while valid and not ready.
REQ-019 Only one valid: that requester SHALL be granted.
REQ-020 Both valid: grant SHALL go to the requester not granted most recently (round-robin); after reset, requester 0 wins first tie.
REQ-021 Latency: rspN_valid SHALL pulse exactly one cycle after acceptance, rspN_value = table content at accepted key as of acceptance edge.
REQ-022 rspN_value SHALL hold its last value when rspN_valid=0; reset value 0.
REQ-023 cfg_we=1 in RUN SHALL write cfg_value to cfg_key at that edge and SHALL force both readies to 0 that cycle (write priority); round-robin pointer unchanged.
REQ-024 Lookup of key K on the cycle after a write to K SHALL return the new value.
REQ-025 Ungranted requester SHALL keep waiting; no request dropped, no starvation beyond one grant when cfg_we low.

Reset
REQ-026 Reset SHALL set: state INIT, counter 0, rr pointer favouring requester 0, rsp*_valid 0, rsp*_value 0, init_done 0.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL restart INIT and discard any pending response; configured entries are overwritten by defaults.

Configuration
REQ-028 Macro LUT_CFG_WRITE_EN defined: cfg_we/cfg_key/cfg_value behave per REQ-023/024.
REQ-029 LUT_CFG_WRITE_EN undefined: cfg ports present but ignored, table holds defaults permanently, readies never blocked by cfg_we.

Structure
REQ-030 Package lut_pkg SHALL hold KEY_W/VAL_W defaults, FSM state enum, and default-entry function (key -> value).
REQ-031 Sub-module lut_rr_arb SHALL implement the 2-way round-robin grant (inputs: two valids, block; outputs: two grants; internal last-grant register).

Verification
REQ-032 Reset, hold both valids high -> readies 0 for 16 cycles, init_done rises on cycle 17, no rsp pulses during INIT.
REQ-033 RUN, req0 key 2 alone -> ready0=1, next cycle rsp0_valid=1, rsp0_value=0x05.
REQ-034 RUN, both valid every cycle, keys 0 and 9 -> grants alternate 0,1,0,1; rsp values 0x01 / 0xFF alternating.
REQ-035 With LUT_CFG_WRITE_EN: cfg_we key 9 value 0x3C with req1 key 9 valid -> ready1=0 that cycle, accepted next cycle, rsp1_value=0x3C.
REQ-036 Without LUT_CFG_WRITE_EN: same stimulus -> accepted immediately, rsp1_value=0xFF.
REQ-037 Reset asserted 3 cycles into RUN after write of 0x3C to key 9 -> INIT restarts, pending rsp suppressed, later lookup key 9 returns 0xFF.
